// File: rtl/mesh_test_sequencer_if.sv
// Mesh-facing bundle: PE configuration and enable driven by the sequencer,
// per-PE completion flags returned by the mesh.
interface mesh_test_sequencer_if;
   logic [7:0]   pe_enable;
   logic [7:0]   pe_dbg_mode_wire;
   logic [7:0]   pe_flush_wire;
   logic [23:0]  pe_send_num_wire;
   logic [23:0]  pe_receive_num_wire;
   logic [31:0]  pe_rate_wire;
   logic [31:0]  pe_mode_wire;
   logic [191:0] pe_dst_seq_wire;
   logic [7:0]   pe_task_send_finish_flag;
   logic [7:0]   pe_task_receive_finish_flag;

   modport master (
      output pe_enable, pe_dbg_mode_wire, pe_flush_wire, pe_send_num_wire,
             pe_receive_num_wire, pe_rate_wire, pe_mode_wire, pe_dst_seq_wire,
      input  pe_task_send_finish_flag, pe_task_receive_finish_flag
   );

   modport slave (
      input  pe_enable, pe_dbg_mode_wire, pe_flush_wire, pe_send_num_wire,
             pe_receive_num_wire, pe_rate_wire, pe_mode_wire, pe_dst_seq_wire,
      output pe_task_send_finish_flag, pe_task_receive_finish_flag
   );
endinterface

// File: rtl/mesh_test_sequencer.sv
// Drives 8-PE mesh traffic patterns one at a time (or all seven in order),
// waits for PE completion or a per-pattern timeout, and records the results.
module mesh_test_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned DRAIN_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            pattern_sel,
   input  logic                  run_all,
   input  logic                  abort,
   input  logic [15:0]           timeout_limit,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            cur_pattern,
   output logic [6:0]            pass_vec,
   output logic [6:0]            timeout_vec,
   output logic                  aborted,
   output logic [15:0]           last_latency,
   mesh_test_sequencer_if.master mesh
);

   typedef enum logic [2:0] {StIdle, StConfig, StRun, StDrain, StDone} state_e;

   function automatic logic [2:0] dst_of(input logic [2:0] p, input logic [2:0] i);
      case (p)
         3'd0:    dst_of = ~i;
         3'd1:    dst_of = {i[0], i[1], i[2]};
         3'd2:    dst_of = {i[0], i[2:1]};
         3'd3:    dst_of = {i[1:0], i[2]};
         3'd4:    dst_of = i + 3'd3;
         3'd5:    dst_of = i + 3'd1;
         default: dst_of = 3'd0;
      endcase
   endfunction

   function automatic logic [191:0] dst_bus(input logic [2:0] p);
      logic [191:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b[24*i +: 3] = dst_of(p, 3'(i));
      return b;
   endfunction

   // Hotspot: PE0 only receives (7 packets), PEs 1-7 only send.
   function automatic logic [23:0] send_bus(input logic [2:0] p);
      logic [23:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b[3*i +: 3] = (p == 3'd6 && i == 0) ? 3'd0 : 3'd1;
      return b;
   endfunction

   function automatic logic [23:0] recv_bus(input logic [2:0] p);
      logic [23:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         if (p == 3'd6) b[3*i +: 3] = (i == 0) ? 3'd7 : 3'd0;
         else           b[3*i +: 3] = 3'd1;
      end
      return b;
   endfunction

   state_e         state_q, state_d;
   logic [2:0]     cur_q, cur_d;
   logic           run_all_q, run_all_d;
   logic [15:0]    cnt_q, cnt_d, cnt_inc;
   logic [6:0]     pass_q, pass_d;
   logic [6:0]     to_q, to_d;
   logic           aborted_q, aborted_d;
   logic [15:0]    lat_q, lat_d;
   logic [23:0]    send_num_q, send_num_d;
   logic [23:0]    recv_num_q, recv_num_d;
   logic [191:0]   dst_q, dst_d;
   logic           cfg_load;
   logic           complete;
   logic           flags_idle;

   always_comb begin
      complete = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (!(mesh.pe_task_send_finish_flag[i] || send_num_q[3*i +: 3] == 3'd0)) begin
            complete = 1'b0;
         end
         if (!(mesh.pe_task_receive_finish_flag[i] || recv_num_q[3*i +: 3] == 3'd0)) begin
            complete = 1'b0;
         end
      end
   end

   assign flags_idle = ~|{mesh.pe_task_send_finish_flag, mesh.pe_task_receive_finish_flag};
   assign cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      run_all_d = run_all_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      to_d      = to_q;
      aborted_d = aborted_q;
      lat_d     = lat_q;
      cfg_load  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && (run_all || pattern_sel != 3'd7)) begin
               state_d   = StConfig;
               cur_d     = run_all ? 3'd0 : pattern_sel;
               run_all_d = run_all;
               pass_d    = '0;
               to_d      = '0;
               aborted_d = 1'b0;
               cnt_d     = 16'd1;
               cfg_load  = 1'b1;
            end
         end
         StConfig: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = StDrain;
               cnt_d     = 16'd1;
            end else if ({16'd0, cnt_q} >= SETTLE_CYCLES && flags_idle) begin
               state_d = StRun;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StRun: begin
            // cnt_q is the 1-based RUN cycle; >= makes a zero limit expire in cycle 1.
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = StDrain;
               cnt_d     = 16'd1;
            end else if (complete) begin
               pass_d[cur_q] = 1'b1;
               lat_d         = cnt_q;
               state_d       = StDrain;
               cnt_d         = 16'd1;
            end else if (cnt_q >= timeout_limit) begin
               to_d[cur_q] = 1'b1;
               state_d     = StDrain;
               cnt_d       = 16'd1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StDrain: begin
            if ({16'd0, cnt_q} >= DRAIN_CYCLES) begin
               if (run_all_q && !aborted_q && cur_q < 3'd6) begin
                  cur_d    = cur_q + 3'd1;
                  state_d  = StConfig;
                  cnt_d    = 16'd1;
                  cfg_load = 1'b1;
               end else begin
                  state_d = StDone;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      send_num_d = cfg_load ? send_bus(cur_d) : send_num_q;
      recv_num_d = cfg_load ? recv_bus(cur_d) : recv_num_q;
      dst_d      = cfg_load ? dst_bus(cur_d)  : dst_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cur_q      <= '0;
         run_all_q  <= 1'b0;
         cnt_q      <= '0;
         pass_q     <= '0;
         to_q       <= '0;
         aborted_q  <= 1'b0;
         lat_q      <= '0;
         send_num_q <= send_bus(3'd0);
         recv_num_q <= recv_bus(3'd0);
         dst_q      <= dst_bus(3'd0);
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         run_all_q  <= run_all_d;
         cnt_q      <= cnt_d;
         pass_q     <= pass_d;
         to_q       <= to_d;
         aborted_q  <= aborted_d;
         lat_q      <= lat_d;
         send_num_q <= send_num_d;
         recv_num_q <= recv_num_d;
         dst_q      <= dst_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign cur_pattern  = cur_q;
   assign pass_vec     = pass_q;
   assign timeout_vec  = to_q;
   assign aborted      = aborted_q;
   assign last_latency = lat_q;

   assign mesh.pe_enable           = (state_q == StRun) ? 8'hFF : 8'h00;
   assign mesh.pe_dbg_mode_wire    = 8'hFF;
   assign mesh.pe_flush_wire       = 8'hFF;
   assign mesh.pe_rate_wire        = 32'h0;
   assign mesh.pe_mode_wire        = {8{4'b0001}};
   assign mesh.pe_send_num_wire    = send_num_q;
   assign mesh.pe_receive_num_wire = recv_num_q;
   assign mesh.pe_dst_seq_wire     = dst_q;

endmodule

// File: tb/tb_mesh_test_sequencer.sv
// Self-checking bench: table vectors, randomized runs against a pattern-level
// reference model, and hand-written sequences for stale flags, abort and reset.
module tb_mesh_test_sequencer;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned DRAIN  = 2;

   logic        clk = 1'b0;
   logic        rst, start, run_all, abort;
   logic [2:0]  pattern_sel;
   logic [15:0] timeout_limit;
   logic        busy, done, aborted;
   logic [2:0]  cur_pattern;
   logic [6:0]  pass_vec, timeout_vec;
   logic [15:0] last_latency;

   mesh_test_sequencer_if dut_if ();

   mesh_test_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .DRAIN_CYCLES  (DRAIN)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .pattern_sel   (pattern_sel),
      .run_all       (run_all),
      .abort         (abort),
      .timeout_limit (timeout_limit),
      .busy          (busy),
      .done          (done),
      .cur_pattern   (cur_pattern),
      .pass_vec      (pass_vec),
      .timeout_vec   (timeout_vec),
      .aborted       (aborted),
      .last_latency  (last_latency),
      .mesh          (dut_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Mesh model: flags rise lat_tab[p] cycles into RUN (0 = never).
   int         lat_tab [7];
   bit         stale     = 1'b0;
   logic [7:0] drop_recv = 8'h00;
   int         en_cnt    = 0;
   logic [7:0] m_s, m_r;
   int         m_l;

   initial begin
      dut_if.pe_task_send_finish_flag    = '0;
      dut_if.pe_task_receive_finish_flag = '0;
      forever begin
         @(posedge clk);
         #1;
         if (dut_if.pe_enable == 8'hFF) en_cnt++;
         else en_cnt = 0;
         m_s = '0;
         m_r = '0;
         m_l = (cur_pattern < 3'd7) ? lat_tab[cur_pattern] : 0;
         if (stale) begin
            m_s = '1;
            m_r = '1;
         end else if (en_cnt != 0 && m_l != 0 && en_cnt >= m_l) begin
            for (int i = 0; i < 8; i++) begin
               m_s[i] = (dut_if.pe_send_num_wire[3*i +: 3] != 3'd0);
               m_r[i] = (dut_if.pe_receive_num_wire[3*i +: 3] != 3'd0) && !drop_recv[i];
            end
         end
         dut_if.pe_task_send_finish_flag    = m_s;
         dut_if.pe_task_receive_finish_flag = m_r;
      end
   end

   // Reference configuration, straight from the pattern definitions.
   function automatic logic [191:0] exp_dst(input int p);
      logic [191:0] b;
      int d;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         case (p)
            0:       d = 7 - i;
            1:       d = (i % 2) * 4 + (i & 2) + i / 4;
            2:       d = (i % 2) * 4 + i / 2;
            3:       d = (i * 2) % 8 + i / 4;
            4:       d = (i + 3) % 8;
            5:       d = (i + 1) % 8;
            default: d = 0;
         endcase
         b[24*i +: 24] = 24'(d);
      end
      return b;
   endfunction

   function automatic logic [23:0] exp_send(input int p);
      return (p == 6) ? 24'o11111110 : 24'o11111111;
   endfunction

   function automatic logic [23:0] exp_recv(input int p);
      return (p == 6) ? 24'o00000007 : 24'o11111111;
   endfunction

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [2:0] sel, input logic ra, input logic [15:0] lim);
      timeout_limit = lim;
      pattern_sel   = sel;
      run_all       = ra;
      start         = 1'b1;
      tick();
      start   = 1'b0;
      run_all = 1'b0;
   endtask

   int run_cycles, done_cnt;
   int seq_pat [$];
   int gaps    [$];

   task automatic wait_done(input int budget);
      int         low_cnt;
      logic [2:0] prev_pat;
      bit         prev_en, seen;
      run_cycles = 0;
      done_cnt   = 0;
      seq_pat.delete();
      gaps.delete();
      low_cnt  = 0;
      prev_pat = cur_pattern;
      prev_en  = 1'b0;
      seen     = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         tick();
         if (dut_if.pe_enable == 8'hFF) begin
            if (!prev_en) seq_pat.push_back(int'(cur_pattern));
            run_cycles++;
            low_cnt = 0;
            prev_en = 1'b1;
         end else begin
            if (cur_pattern != prev_pat) gaps.push_back(low_cnt);
            low_cnt++;
            prev_en = 1'b0;
         end
         prev_pat = cur_pattern;
         if (done) begin
            done_cnt++;
            seen = 1'b1;
         end
      end
      chk("done_seen", 192'(seen), 192'd1);
      tick();
      if (done) done_cnt++;
      chk("idle_after_done", 192'(busy), 192'd0);
   endtask

   typedef struct {
      logic [2:0] sel;
      int         lat;
      int         limit;
      logic [6:0] pass;
      logic [6:0] to;
      int         lat_out;
      int         run_len;
   } vec_t;

   vec_t       vecs [7];
   int         model_lat;
   logic [6:0] e_pass, e_to;
   int         e_run, first, last, eff, en_hi, sel_r;
   bit         ra_r;

   initial begin
      vecs[0] = '{3'd1, 10, 100, 7'h02, 7'h00, 10, 10};
      vecs[1] = '{3'd6,  3, 100, 7'h40, 7'h00,  3,  3};
      vecs[2] = '{3'd0,  1,   0, 7'h01, 7'h00,  1,  1};
      vecs[3] = '{3'd4,  0,   0, 7'h00, 7'h10,  1,  1};
      vecs[4] = '{3'd2, 20,  20, 7'h04, 7'h00, 20, 20};
      vecs[5] = '{3'd5, 21,  20, 7'h00, 7'h20, 20, 20};
      vecs[6] = '{3'd3,  0,  50, 7'h00, 7'h08, 20, 50};

      for (int p = 0; p < 7; p++) lat_tab[p] = 0;
      rst = 1'b1; start = 1'b0; run_all = 1'b0; abort = 1'b0;
      pattern_sel = 3'd0; timeout_limit = 16'd100;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_busy",     192'(busy),               192'd0);
      chk("rst_done",     192'(done),               192'd0);
      chk("rst_enable",   192'(dut_if.pe_enable),   192'd0);
      chk("rst_cur",      192'(cur_pattern),        192'd0);
      chk("rst_pass",     192'(pass_vec),           192'd0);
      chk("rst_to",       192'(timeout_vec),        192'd0);
      chk("rst_aborted",  192'(aborted),            192'd0);
      chk("rst_latency",  192'(last_latency),       192'd0);
      chk("rst_dst",      dut_if.pe_dst_seq_wire,   exp_dst(0));
      chk("rst_send",     192'(dut_if.pe_send_num_wire),    192'(exp_send(0)));
      chk("rst_recv",     192'(dut_if.pe_receive_num_wire), 192'(exp_recv(0)));
      chk("const_mode",   192'(dut_if.pe_mode_wire),     192'h11111111);
      chk("const_rate",   192'(dut_if.pe_rate_wire),     192'd0);
      chk("const_dbg",    192'(dut_if.pe_dbg_mode_wire), 192'hFF);
      chk("const_flush",  192'(dut_if.pe_flush_wire),    192'hFF);

      // Invalid selection without run_all is ignored.
      pulse_start(3'd7, 1'b0, 16'd100);
      tick();
      chk("invalid_start", 192'(busy), 192'd0);

      for (int v = 0; v < 7; v++) begin
         for (int p = 0; p < 7; p++) lat_tab[p] = 0;
         lat_tab[vecs[v].sel] = vecs[v].lat;
         pulse_start(vecs[v].sel, 1'b0, 16'(vecs[v].limit));
         wait_done(3000);
         chk("vec_pass",    192'(pass_vec),     192'(vecs[v].pass));
         chk("vec_to",      192'(timeout_vec),  192'(vecs[v].to));
         chk("vec_latency", 192'(last_latency), 192'(vecs[v].lat_out));
         chk("vec_run_len", 192'(run_cycles),   192'(vecs[v].run_len));
         chk("vec_done",    192'(done_cnt),     192'd1);
         chk("vec_dst",     dut_if.pe_dst_seq_wire, exp_dst(int'(vecs[v].sel)));
         chk("vec_send",    192'(dut_if.pe_send_num_wire),    192'(exp_send(int'(vecs[v].sel))));
         chk("vec_recv",    192'(dut_if.pe_receive_num_wire), 192'(exp_recv(int'(vecs[v].sel))));
      end
      model_lat = 20;

      // Hotspot with PE0's receive flag missing must time out.
      for (int p = 0; p < 7; p++) lat_tab[p] = 0;
      lat_tab[6] = 2;
      drop_recv  = 8'h01;
      pulse_start(3'd6, 1'b0, 16'd30);
      wait_done(3000);
      drop_recv = 8'h00;
      chk("hot_missing_pass", 192'(pass_vec),    192'd0);
      chk("hot_missing_to",   192'(timeout_vec), 192'h40);
      chk("hot_missing_run",  192'(run_cycles),  192'd30);

      // Full run_all sweep with a responsive mesh.
      for (int p = 0; p < 7; p++) lat_tab[p] = 3 + p;
      pulse_start(3'd7, 1'b1, 16'd100);
      wait_done(3000);
      model_lat = 9;
      chk("all_pass",    192'(pass_vec),     192'h7F);
      chk("all_done",    192'(done_cnt),     192'd1);
      chk("all_cur",     192'(cur_pattern),  192'd6);
      chk("all_latency", 192'(last_latency), 192'(model_lat));
      chk("all_nseq",    192'(seq_pat.size()), 192'd7);
      for (int k = 0; k < seq_pat.size(); k++) chk("all_seq", 192'(seq_pat[k]), 192'(k));
      chk("all_ngaps",   192'(gaps.size()),  192'd6);
      for (int k = 0; k < gaps.size(); k++) chk("all_drain_gap", 192'(gaps[k]), 192'(DRAIN));

      // abort while idle does nothing.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("idle_abort_flag", 192'(aborted), 192'd0);
      chk("idle_abort_busy", 192'(busy),    192'd0);

      // start while busy is ignored.
      for (int p = 0; p < 7; p++) lat_tab[p] = 0;
      lat_tab[2] = 15;
      pulse_start(3'd2, 1'b0, 16'd100);
      for (int k = 0; k < 8; k++) tick();
      pulse_start(3'd5, 1'b1, 16'd100);
      wait_done(3000);
      chk("busy_start_cur",  192'(cur_pattern), 192'd2);
      chk("busy_start_pass", 192'(pass_vec),    192'h04);
      chk("busy_start_done", 192'(done_cnt),    192'd1);
      model_lat = 15;

      // Stale flags hold the sequencer in CONFIG.
      for (int p = 0; p < 7; p++) lat_tab[p] = 0;
      lat_tab[0] = 5;
      stale = 1'b1;
      tick();
      tick();
      pulse_start(3'd0, 1'b0, 16'd100);
      en_hi = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (dut_if.pe_enable != 8'h00) en_hi++;
      end
      chk("stale_no_run", 192'(en_hi), 192'd0);
      chk("stale_busy",   192'(busy),  192'd1);
      stale = 1'b0;
      wait_done(3000);
      model_lat = 5;
      chk("stale_pass", 192'(pass_vec),   192'h01);
      chk("stale_run",  192'(run_cycles), 192'd5);

      // Abort mid-RUN during run_all stops the sweep.
      for (int p = 0; p < 7; p++) lat_tab[p] = 0;
      pulse_start(3'd7, 1'b1, 16'd1000);
      for (int k = 0; k < 50 && dut_if.pe_enable != 8'hFF; k++) tick();
      chk("abort_reach_run", 192'(dut_if.pe_enable), 192'hFF);
      for (int k = 0; k < 4; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done(100);
      chk("abort_flag",  192'(aborted),     192'd1);
      chk("abort_pass",  192'(pass_vec),    192'd0);
      chk("abort_to",    192'(timeout_vec), 192'd0);
      chk("abort_cur",   192'(cur_pattern), 192'd0);
      chk("abort_done",  192'(done_cnt),    192'd1);
      chk("abort_gaps",  192'(gaps.size()), 192'd0);

      // Randomized runs against the pattern-level model.
      for (int it = 0; it < 16; it++) begin
         sel_r = $urandom_range(0, 6);
         ra_r  = ($urandom_range(0, 3) == 0);
         timeout_limit = 16'($urandom_range(0, 30));
         for (int p = 0; p < 7; p++)
            lat_tab[p] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 25);
         first  = ra_r ? 0 : sel_r;
         last   = ra_r ? 6 : sel_r;
         eff    = (timeout_limit == 16'd0) ? 1 : int'(timeout_limit);
         e_pass = '0;
         e_to   = '0;
         e_run  = 0;
         for (int p = first; p <= last; p++) begin
            if (lat_tab[p] != 0 && lat_tab[p] <= eff) begin
               e_pass[p] = 1'b1;
               model_lat = lat_tab[p];
               e_run += lat_tab[p];
            end else begin
               e_to[p] = 1'b1;
               e_run += eff;
            end
         end
         pulse_start(3'(sel_r), ra_r, timeout_limit);
         wait_done(3000);
         chk("rnd_pass",    192'(pass_vec),     192'(e_pass));
         chk("rnd_to",      192'(timeout_vec),  192'(e_to));
         chk("rnd_latency", 192'(last_latency), 192'(model_lat));
         chk("rnd_run",     192'(run_cycles),   192'(e_run));
         chk("rnd_cur",     192'(cur_pattern),  192'(last));
         chk("rnd_done",    192'(done_cnt),     192'd1);
      end

      // Reset mid-RUN returns everything to reset values on the next edge.
      for (int p = 0; p < 7; p++) lat_tab[p] = 0;
      pulse_start(3'd3, 1'b0, 16'd1000);
      for (int k = 0; k < 50 && dut_if.pe_enable != 8'hFF; k++) tick();
      chk("rst_mid_reach_run", 192'(dut_if.pe_enable), 192'hFF);
      tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_busy",    192'(busy),             192'd0);
      chk("rst_mid_done",    192'(done),             192'd0);
      chk("rst_mid_enable",  192'(dut_if.pe_enable), 192'd0);
      chk("rst_mid_cur",     192'(cur_pattern),      192'd0);
      chk("rst_mid_pass",    192'(pass_vec),         192'd0);
      chk("rst_mid_to",      192'(timeout_vec),      192'd0);
      chk("rst_mid_aborted", 192'(aborted),          192'd0);
      chk("rst_mid_latency", 192'(last_latency),     192'd0);
      chk("rst_mid_dst",     dut_if.pe_dst_seq_wire, exp_dst(0));
      chk("rst_mid_recv",    192'(dut_if.pe_receive_num_wire), 192'(exp_recv(0)));
      rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
